// File: rtl/class_egress_arb.sv
// class_egress_arb: weighted round-robin merge of the two per-class egress
// FIFOs of the class dispatcher onto a single egress word stream, with
// almost-full backpressure and per-class forwarded-word counters.
module class_egress_arb #(
  parameter int DATA_W  = 10,
  parameter int WEIGHT0 = 2,
  parameter int WEIGHT1 = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_empty,
  output logic              in0_pop,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_empty,
  output logic              in1_pop,
  input  logic              out_almost_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  output logic              active,
  output logic [CNT_W-1:0]  fwd_cnt0,
  output logic [CNT_W-1:0]  fwd_cnt1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam logic [2:0] W0 = WEIGHT0[2:0];
  localparam logic [2:0] W1 = WEIGHT1[2:0];

  logic [1:0] state, state_nxt;
  logic [2:0] burst, burst_nxt;
  logic       last, last_nxt;
  logic       ok;
  logic       p1_valid;
  logic       p1_src;

  assign ok     = !out_almost_full;
  assign active = (state != IDLE);

  // Arbitration decision: pops and next state are combinational so a pop
  // never lands on an empty FIFO and backpressure takes effect the same cycle.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    last_nxt  = last;
    in0_pop   = 1'b0;
    in1_pop   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (ok && !in0_empty && (in1_empty || last)) begin
            in0_pop   = 1'b1;
            state_nxt = SERVE0;
            burst_nxt = 3'd1;
          end else if (ok && !in1_empty) begin
            in1_pop   = 1'b1;
            state_nxt = SERVE1;
            burst_nxt = 3'd1;
          end
        end
        SERVE0: begin
          if (ok) begin
            if (!in0_empty && ((burst < W0) || in1_empty)) begin
              in0_pop = 1'b1;
              if (burst < W0) burst_nxt = burst + 3'd1;
            end else if (!in1_empty) begin
              in1_pop   = 1'b1;
              state_nxt = SERVE1;
              burst_nxt = 3'd1;
              last_nxt  = 1'b0;
            end else begin
              state_nxt = IDLE;
              burst_nxt = 3'd0;
              last_nxt  = 1'b0;
            end
          end
        end
        SERVE1: begin
          if (ok) begin
            if (!in1_empty && ((burst < W1) || in0_empty)) begin
              in1_pop = 1'b1;
              if (burst < W1) burst_nxt = burst + 3'd1;
            end else if (!in0_empty) begin
              in0_pop   = 1'b1;
              state_nxt = SERVE0;
              burst_nxt = 3'd1;
              last_nxt  = 1'b1;
            end else begin
              state_nxt = IDLE;
              burst_nxt = 3'd0;
              last_nxt  = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          burst_nxt = 3'd0;
        end
      endcase
    end
  end

  // Arbiter state; last starts at 1 so class 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      burst <= 3'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      burst <= burst_nxt;
      last  <= last_nxt;
    end
  end

  // Two-stage datapath: remember which class was popped, then capture the
  // FIFO read data the following cycle; out_data holds between words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_valid  <= 1'b0;
      p1_src    <= 1'b0;
      out_valid <= 1'b0;
      out_src   <= 1'b0;
      out_data  <= '0;
    end else begin
      p1_valid  <= in0_pop | in1_pop;
      p1_src    <= in1_pop;
      out_valid <= p1_valid;
      if (p1_valid) begin
        out_data <= p1_src ? in1_data : in0_data;
        out_src  <= p1_src;
      end
    end
  end

  // Per-class forwarded-word counters, free-running with wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt0 <= '0;
      fwd_cnt1 <= '0;
    end else if (out_valid) begin
      if (out_src) fwd_cnt1 <= fwd_cnt1 + 1'b1;
      else         fwd_cnt0 <= fwd_cnt0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_class_egress_arb.sv
// Testbench for class_egress_arb: two model FIFOs with registered read data
// feed the arbiter; each task drives a directed scenario and checks inline.
module tb_class_egress_arb;

  logic       clk;
  logic       reset;
  logic [9:0] in0_data = '0;
  logic       in0_empty;
  logic       in0_pop;
  logic [9:0] in1_data = '0;
  logic       in1_empty;
  logic       in1_pop;
  logic       out_almost_full;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_src;
  logic       active;
  logic [7:0] fwd_cnt0;
  logic [7:0] fwd_cnt1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] mem0 [1024];
  logic [9:0] mem1 [1024];
  int wr0 = 0;
  int wr1 = 0;
  int rd0 = 0;
  int rd1 = 0;

  class_egress_arb #(.DATA_W(10), .WEIGHT0(2), .WEIGHT1(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_empty(in0_empty), .in0_pop(in0_pop),
    .in1_data(in1_data), .in1_empty(in1_empty), .in1_pop(in1_pop),
    .out_almost_full(out_almost_full),
    .out_data(out_data), .out_valid(out_valid), .out_src(out_src),
    .active(active), .fwd_cnt0(fwd_cnt0), .fwd_cnt1(fwd_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model FIFOs: read data appears the cycle after a pop.
  assign in0_empty = (rd0 == wr0);
  assign in1_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (in0_pop) begin
      in0_data <= mem0[rd0];
      rd0      <= rd0 + 1;
    end
    if (in1_pop) begin
      in1_data <= mem1[rd1];
      rd1      <= rd1 + 1;
    end
  end

  task automatic push0(input logic [9:0] v);
    mem0[wr0] = v;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [9:0] v);
    mem1[wr1] = v;
    wr1 = wr1 + 1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({in0_pop, in1_pop, out_valid, out_src, active, out_data, fwd_cnt0, fwd_cnt1} !== 31'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got pop0=%b pop1=%b valid=%b src=%b active=%b data=%h c0=%0d c1=%0d, want all 0",
               in0_pop, in1_pop, out_valid, out_src, active, out_data, fwd_cnt0, fwd_cnt1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({out_valid, active, in0_pop, in1_pop} !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle: got valid=%b active=%b pops=%b%b, want 0",
               out_valid, active, in0_pop, in1_pop);
    end
  endtask

  task automatic test_single_class;
    logic [9:0] exp_data;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push0(10'h011 + 10'(i));
    for (int j = 0; j < 8; j++) begin
      #1;
      tests_run++;
      if ({in0_pop, in1_pop} !== {(j < 5), 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL single_pop[%0d]: got pop0=%b pop1=%b, want pop0=%b pop1=0", j, in0_pop, in1_pop, (j < 5));
      end
      tests_run++;
      if ({out_valid, active} !== {(j >= 2 && j <= 6), (j >= 1 && j <= 5)}) begin
        tests_failed++;
        $display("[TB] FAIL single_valid_active[%0d]: got valid=%b active=%b, want valid=%b active=%b",
                 j, out_valid, active, (j >= 2 && j <= 6), (j >= 1 && j <= 5));
      end
      exp_data = (j >= 2 && j <= 6) ? 10'h011 + 10'(j - 2) : 10'h015;
      if (j >= 2) begin
        tests_run++;
        if ({out_src, out_data} !== {1'b0, exp_data}) begin
          tests_failed++;
          $display("[TB] FAIL single_data[%0d]: got src=%b data=%h, want src=0 data=%h", j, out_src, out_data, exp_data);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if ({fwd_cnt0, fwd_cnt1} !== {8'd5, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL single_counts: got c0=%0d c1=%0d, want c0=5 c1=0", fwd_cnt0, fwd_cnt1);
    end
  endtask

  // Entered with last=0, so class 1 wins the tie.
  task automatic test_tie;
    logic [3:0] p0v = 4'b0010;
    logic [3:0] p1v = 4'b0101;
    logic [5:0] vv  = 6'b011100;
    logic [5:0] sv  = 6'b010100;
    logic [9:0] dv [6];
    dv[2] = 10'h0C0; dv[3] = 10'h040; dv[4] = 10'h0C1;
    @(negedge clk);
    push0(10'h040);
    push1(10'h0C0);
    push1(10'h0C1);
    for (int j = 0; j < 6; j++) begin
      #1;
      if (j < 4) begin
        tests_run++;
        if ({in0_pop, in1_pop} !== {p0v[j], p1v[j]}) begin
          tests_failed++;
          $display("[TB] FAIL tie_pop[%0d]: got pop0=%b pop1=%b, want pop0=%b pop1=%b", j, in0_pop, in1_pop, p0v[j], p1v[j]);
        end
      end
      tests_run++;
      if (out_valid !== vv[j]) begin
        tests_failed++;
        $display("[TB] FAIL tie_valid[%0d]: got %b, want %b", j, out_valid, vv[j]);
      end
      if (vv[j]) begin
        tests_run++;
        if ({out_src, out_data} !== {sv[j], dv[j]}) begin
          tests_failed++;
          $display("[TB] FAIL tie_data[%0d]: got src=%b data=%h, want src=%b data=%h", j, out_src, out_data, sv[j], dv[j]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if ({fwd_cnt0, fwd_cnt1, active} !== {8'd6, 8'd2, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL tie_counts: got c0=%0d c1=%0d active=%b, want c0=6 c1=2 active=0", fwd_cnt0, fwd_cnt1, active);
    end
  endtask

  task automatic test_weighted_interleave;
    logic [11:0] seq = 12'b1111_0010_0100;
    logic [9:0]  exp_data;
    int k0 = 0;
    int k1 = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push0(10'h100 + 10'(i));
      push1(10'h200 + 10'(i));
    end
    for (int j = 0; j < 15; j++) begin
      #1;
      tests_run++;
      if (j < 12) begin
        if ({in0_pop, in1_pop} !== {~seq[j], seq[j]}) begin
          tests_failed++;
          $display("[TB] FAIL wrr_pop[%0d]: got pop0=%b pop1=%b, want pop0=%b pop1=%b", j, in0_pop, in1_pop, ~seq[j], seq[j]);
        end
      end else if ({in0_pop, in1_pop} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL wrr_pop[%0d]: got pop0=%b pop1=%b, want none", j, in0_pop, in1_pop);
      end
      tests_run++;
      if (out_valid !== (j >= 2 && j <= 13)) begin
        tests_failed++;
        $display("[TB] FAIL wrr_valid[%0d]: got %b, want %b", j, out_valid, (j >= 2 && j <= 13));
      end
      if (j >= 2 && j <= 13) begin
        if (seq[j-2]) begin
          exp_data = 10'h200 + 10'(k1);
          k1++;
        end else begin
          exp_data = 10'h100 + 10'(k0);
          k0++;
        end
        tests_run++;
        if ({out_src, out_data} !== {seq[j-2], exp_data}) begin
          tests_failed++;
          $display("[TB] FAIL wrr_data[%0d]: got src=%b data=%h, want src=%b data=%h", j, out_src, out_data, seq[j-2], exp_data);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if ({fwd_cnt0, fwd_cnt1} !== {8'd12, 8'd8}) begin
      tests_failed++;
      $display("[TB] FAIL wrr_counts: got c0=%0d c1=%0d, want c0=12 c1=8", fwd_cnt0, fwd_cnt1);
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] p0v = 12'b0000_1010_0001;
    logic [11:0] p1v = 12'b0001_0100_0000;
    logic [11:0] vv  = 12'b0111_1000_0100;
    logic [11:0] sv  = 12'b0101_0000_0000;
    logic [9:0]  exp_data;
    int k0 = 0;
    int k1 = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push0(10'h300 + 10'(i));
    for (int i = 0; i < 2; i++) push1(10'h380 + 10'(i));
    for (int j = 0; j < 12; j++) begin
      if (j == 1) out_almost_full = 1'b1;
      if (j == 5) out_almost_full = 1'b0;
      #1;
      tests_run++;
      if ({in0_pop, in1_pop} !== {p0v[j], p1v[j]}) begin
        tests_failed++;
        $display("[TB] FAIL bp_pop[%0d]: got pop0=%b pop1=%b, want pop0=%b pop1=%b", j, in0_pop, in1_pop, p0v[j], p1v[j]);
      end
      tests_run++;
      if (out_valid !== vv[j]) begin
        tests_failed++;
        $display("[TB] FAIL bp_valid[%0d]: got %b, want %b", j, out_valid, vv[j]);
      end
      if (vv[j]) begin
        if (sv[j]) begin
          exp_data = 10'h380 + 10'(k1);
          k1++;
        end else begin
          exp_data = 10'h300 + 10'(k0);
          k0++;
        end
        tests_run++;
        if ({out_src, out_data} !== {sv[j], exp_data}) begin
          tests_failed++;
          $display("[TB] FAIL bp_data[%0d]: got src=%b data=%h, want src=%b data=%h", j, out_src, out_data, sv[j], exp_data);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if ({fwd_cnt0, fwd_cnt1, active} !== {8'd15, 8'd10, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL bp_counts: got c0=%0d c1=%0d active=%b, want c0=15 c1=10 active=0", fwd_cnt0, fwd_cnt1, active);
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push0(10'h0A0 + 10'(i));
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 10'h0A0}) begin
      tests_failed++;
      $display("[TB] FAIL midreset_inflight: got valid=%b data=%h, want valid=1 data=0a0", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({in0_pop, in1_pop, out_valid, out_src, active, out_data, fwd_cnt0, fwd_cnt1} !== 31'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got pop0=%b pop1=%b valid=%b src=%b active=%b data=%h c0=%0d c1=%0d, want all 0",
               in0_pop, in1_pop, out_valid, out_src, active, out_data, fwd_cnt0, fwd_cnt1);
    end
    wr0 = rd0;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      tests_run++;
      if ({out_valid, active, in0_pop, in1_pop} !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_quiet[%0d]: got valid=%b active=%b pops=%b%b, want 0", j, out_valid, active, in0_pop, in1_pop);
      end
      @(negedge clk);
    end
    push0(10'h0B5);
    for (int j = 0; j < 4; j++) begin
      #1;
      if (j == 0) begin
        tests_run++;
        if ({in0_pop, in1_pop} !== 2'b10) begin
          tests_failed++;
          $display("[TB] FAIL midreset_newpop: got pop0=%b pop1=%b, want pop0=1 pop1=0", in0_pop, in1_pop);
        end
      end
      if (j == 2) begin
        tests_run++;
        if ({out_valid, out_src, out_data} !== {1'b1, 1'b0, 10'h0B5}) begin
          tests_failed++;
          $display("[TB] FAIL midreset_newword: got valid=%b src=%b data=%h, want valid=1 src=0 data=0b5", out_valid, out_src, out_data);
        end
      end
      if (j == 3) begin
        tests_run++;
        if ({fwd_cnt0, fwd_cnt1} !== {8'd1, 8'd0}) begin
          tests_failed++;
          $display("[TB] FAIL midreset_counts: got c0=%0d c1=%0d, want c0=1 c1=0", fwd_cnt0, fwd_cnt1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_counter_wrap;
    bit done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 257; i++) push0(10'(i));
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc > 3 && !active && !out_valid && in0_empty) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("[TB] FAIL wrap_timeout: got active=%b valid=%b after 400 cycles, want drained", active, out_valid);
    end
    tests_run++;
    if ({fwd_cnt0, fwd_cnt1} !== {8'd1, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_counts: got c0=%0d c1=%0d, want c0=1 c1=0", fwd_cnt0, fwd_cnt1);
    end
    tests_run++;
    if (out_data !== 10'h100) begin
      tests_failed++;
      $display("[TB] FAIL wrap_lastword: got data=%h, want 100", out_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_tie();
    test_weighted_interleave();
    test_backpressure();
    test_reset_midstream();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
